// File: rtl/frame_buffer_sched.sv
// Ping-pong snapshot scheduler: serially copies game records into the back bank on a game tick
// and swaps banks only at vblank start. Optional statistics counters under FRAME_SCHED_STATS_EN.
module frame_buffer_sched #(
    parameter int NUM_ENTRIES = 10,
    parameter int DATA_W      = 38,
    parameter int AW          = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              game_tick,
    input  logic              vs,
    output logic              src_rd_en,
    output logic [AW-1:0]     src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              front_bank,
    output logic              swap_pulse,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       swap_cnt,
    output logic [7:0]        drop_cnt
);

    localparam int                CW       = $clog2(NUM_ENTRIES + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(NUM_ENTRIES);
    localparam logic [AW:0]       RD_LIMIT = (AW + 1)'(NUM_ENTRIES);
    localparam logic [DATA_W-1:0] DEF_REC  = DATA_W'({10'd700, 10'd700, 9'd500, 9'd500});

    typedef enum logic [1:0] {IDLE, COPY, READY} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     cnt;
    logic              tick_s1, tick_s2, tick_d, vs_d, pend;
    logic              tick_evt, vblank_evt, overrun_evt, restart_evt, wr_en;
    logic [AW-1:0]     wr_idx;
    logic [DATA_W-1:0] bank [2][NUM_ENTRIES];

    assign tick_evt    = tick_s2 & ~tick_d;
    assign vblank_evt  = vs_d & ~vs;
    assign overrun_evt = (state == COPY) && tick_evt && pend;
    // A tick in READY without a coincident vblank discards the stale back bank.
    assign restart_evt = (state == READY) && tick_evt && !vblank_evt;
    assign wr_idx      = AW'(cnt - CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_s1 <= 1'b0;
            tick_s2 <= 1'b0;
            tick_d  <= 1'b0;
            vs_d    <= 1'b0;
        end else begin
            tick_s1 <= game_tick;
            tick_s2 <= tick_s1;
            tick_d  <= tick_s2;
            vs_d    <= vs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (tick_evt) next_state = COPY;
            COPY:  if (cnt == CNT_LAST) next_state = READY;
            READY: begin
                if (vblank_evt)    next_state = (pend || tick_evt) ? COPY : IDLE;
                else if (tick_evt) next_state = COPY;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        src_rd_en  = 1'b0;
        src_addr   = '0;
        swap_pulse = 1'b0;
        wr_en      = 1'b0;
        case (state)
            COPY: begin
                src_rd_en = (cnt != CNT_LAST);
                src_addr  = (cnt != CNT_LAST) ? AW'(cnt) : '0;
                wr_en     = (cnt != '0);
            end
            READY:   swap_pulse = vblank_evt;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            pend       <= 1'b0;
            front_bank <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            busy    <= (next_state == COPY);
            overrun <= overrun | overrun_evt;
            if (state == COPY && cnt != CNT_LAST) cnt <= cnt + CW'(1);
            else if (state != COPY)               cnt <= '0;
            if (swap_pulse) front_bank <= ~front_bank;
            if (state == COPY && tick_evt && !pend)                pend <= 1'b1;
            else if (state == READY && (vblank_evt || restart_evt)) pend <= 1'b0;
        end
    end

    // Writes only ever target the back bank; the front bank changes solely by swapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NUM_ENTRIES; i++)
                    bank[b][i] <= DEF_REC;
        end else if (wr_en) begin
            bank[~front_bank][wr_idx] <= src_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < RD_LIMIT) rd_data = bank[front_bank][rd_addr];
    end

`ifdef FRAME_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            swap_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (swap_pulse) swap_cnt <= swap_cnt + 16'd1;
            if ((overrun_evt || restart_evt) && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign swap_cnt = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: doc/frame_buffer_sched.md
Name: frame_buffer_sched

Overview:
- Ping-pong snapshot scheduler on the VGA pixel clock. It moves per-entry game state (obstacle/trail records) from the game logic into a two-bank shadow store.
- Copying is sequenced by the 60 Hz game tick. The front/back bank swap happens only at vertical-blank start, so the renderer never sees a half-updated frame.
- It replaces the wide parallel VS-gated register copy with a serial, handshaked, tear-free scheduler.

Parameters:
- NUM_ENTRIES, 10, number of records per snapshot (e.g. 10 obstacles)
- DATA_W, 38, bits per record ({x_left[9:0], x_right[9:0], y_up[8:0], y_down[8:0]})
- AW, $clog2(NUM_ENTRIES), address width (derived)

Ports:
- clk  in  1  pixel clock (25 MHz domain)
- rst_n  in  1  synchronous, active-low reset
- game_tick  in  1  60 Hz game clock level from the game domain (asynchronous to clk)
- vs  in  1  VGA vertical sync, active-low
- src_rd_en  out  1  read strobe to the game-side record source
- src_addr  out  AW  record index being read
- src_data  in  DATA_W  record data, valid exactly 1 clk after src_rd_en
- rd_addr  in  AW  renderer read index
- rd_data  out  DATA_W  front-bank record at rd_addr (combinational)
- front_bank  out  1  bank currently displayed
- swap_pulse  out  1  1-cycle pulse on the cycle front_bank toggles
- busy  out  1  high while in COPY
- overrun  out  1  sticky; set when a tick is lost; cleared only by reset

Behaviour:
- Tick sync and edge detect:
  - game_tick passes through a 2-FF synchronizer.
  - tick_evt is the 1-cycle rising-edge pulse of the synchronized signal.
- vblank_evt: 1-cycle pulse on the vs 1→0 edge, taken from a registered copy of vs.
- States are IDLE, COPY, READY.
- IDLE:
  - tick_evt → COPY, with cnt=0.
  - vblank_evt is ignored.
- COPY:
  - Each cycle with cnt<NUM_ENTRIES: src_rd_en=1, src_addr=cnt, cnt++.
  - The write into the back bank (the bank not equal to front_bank) at index = previous src_addr happens on the cycle after each strobe.
  - Leaves COPY after the final write, NUM_ENTRIES+1 cycles after entry, and goes to READY.
  - A tick_evt during COPY sets pend (one-deep).
  - If pend is already set, a further tick_evt sets overrun.
- READY:
  - vblank_evt → toggle front_bank, pulse swap_pulse.
  - Then: if pend, clear pend and → COPY with cnt=0; else → IDLE.
  - tick_evt in READY (newer data arrived before the swap) → COPY restart with cnt=0. The stale back bank is discarded and no swap occurs.
- Simultaneous tick_evt and vblank_evt in READY: the swap takes priority, and the tick sets pend. The next cycle therefore enters COPY.
- vblank_evt during COPY: no swap. The frame keeps the old front bank; the swap waits for the next vblank in READY.
- Back bank:
  - It is never readable via rd_data.
  - Front bank contents change only through a swap, never through a write.
- rd_addr ≥ NUM_ENTRIES → rd_data = 0.
- Reset (synchronous, any state, including mid-COPY):
  - state=IDLE, cnt=0, pend=0, front_bank=0, swap_pulse=0, busy=0, src_rd_en=0, src_addr=0, overrun=0, synchronizer/edge regs=0.
  - Both banks load the off-screen default {700,700,500,500} per record.
- busy = (state==COPY), registered.

Optional Feature:
- Macro: FRAME_SCHED_STATS_EN.
- Defined:
  - Adds output swap_cnt[15:0]: increments on each swap_pulse and wraps at 16'hFFFF→0.
  - Adds output drop_cnt[7:0]: increments whenever overrun would be set (and on each READY restart) and saturates at 8'hFF.
  - Both counters reset to 0.
- Undefined: both ports still exist but are tied to 0, so the port list is identical either way.

Test Plan:
- Reset, then read rd_addr 0..9 → rd_data = {700,700,500,500} for every entry; front_bank=0, busy=0.
- Source returns 38'(addr+1); one tick, then vblank 2 ms later:
  - busy high for exactly 11 clks;
  - swap_pulse once; front_bank=1;
  - rd_data[3]=4.
- Tick, then vblank arriving mid-COPY → no swap on that vblank; the swap occurs on the following vblank; rd_data unchanged in between.
- Tick and vblank on the same cycle while in READY → swap_pulse that cycle, COPY entered the next cycle, pend cleared.
- Three ticks within one COPY → overrun=1; with FRAME_SCHED_STATS_EN, drop_cnt=1.
- Assert rst_n=0 at cnt=5 of COPY → the next cycle is IDLE, src_rd_en=0, front_bank=0, and the banks are back at default values.
